// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage fetch sequencer: imem handshake, single-slot ID buffer, redirects (FETCH_CTRL_PERF_CNT_EN adds perf counters)
module fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              id_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              req_hs;
    logic              rsp_take;
    logic              slot_load;
    logic              slot_pop;
    logic [ADDR_W-1:0] redirect_pc;
    logic              unused_bits;

    // Redirect targets are forced to word alignment; the low address bits are never used.
    assign unused_bits = ^redirect_addr[1:0];
    assign redirect_pc = {redirect_addr[ADDR_W-1:2], 2'b00};

    // Request only when the slot is free or draining, so a response always finds room.
    assign imem_req  = (state == ST_REQ) && (!if_valid || id_ready);
    assign imem_addr = fetch_pc;
    assign req_hs    = imem_req && imem_gnt;

    // Responses only matter while one is outstanding; in IDLE/REQ they are stale leftovers.
    assign rsp_take  = imem_rvalid && ((state == ST_WAIT) || (state == ST_DROP));
    assign slot_load = imem_rvalid && (state == ST_WAIT) && !redirect_valid;
    assign slot_pop  = if_valid && id_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a redirect while a request is outstanding sends us to DROP to swallow it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (req_hs) begin
                    state_nxt = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = ST_REQ;
                end else if (redirect_valid) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (rsp_take) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fetch PC: redirect wins over the sequential +4 advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (req_hs) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    // Remember which address the outstanding request belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_pc <= RESET_PC;
        end else if (req_hs) begin
            inflight_pc <= fetch_pc;
        end
    end

    // Output slot: flush on redirect, refill on response, empty to NOP when ID takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_inst  <= NOP_INST;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end else if (slot_load) begin
            if_valid <= 1'b1;
            if_pc    <= inflight_pc;
            if_inst  <= imem_rdata;
        end else if (slot_pop) begin
            if_valid <= 1'b0;
            if_inst  <= NOP_INST;
        end
    end

`ifdef FETCH_CTRL_PERF_CNT_EN
    // Delivered-instruction and redirect counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (slot_pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        rv;
        logic [31:0] ra;
        logic        idr;
        logic        gnt;
        logic        rvl;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks;
    int n_fail;
    vec_t tbl[$];
    vec_t seq[$];

    fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .id_ready       (id_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
`ifdef FETCH_CTRL_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic idr, input logic gnt,
                                input logic rvl, input logic [31:0] rd, input logic e_req,
                                input logic [31:0] e_addr, input logic e_val, input logic [31:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t v;
        v.rv = rv; v.ra = ra; v.idr = idr; v.gnt = gnt; v.rvl = rvl; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    // Called at a negedge: drive, let combinational outputs settle, compare, advance to next negedge.
    task automatic apply(input vec_t v, input int idx);
        redirect_valid = v.rv;
        redirect_addr  = v.ra;
        id_ready       = v.idr;
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rvl;
        imem_rdata     = v.rd;
        #1;
        chk("imem_req",  idx, {31'd0, imem_req}, {31'd0, v.e_req});
        chk("imem_addr", idx, imem_addr, v.e_addr);
        chk("if_valid",  idx, {31'd0, if_valid}, {31'd0, v.e_val});
        chk("if_pc",     idx, if_pc, v.e_pc);
        chk("if_inst",   idx, if_inst, v.e_inst);
        @(negedge clk);
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_req",   idx, {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  idx, imem_addr, 32'h0);
        chk("rst_valid", idx, {31'd0, if_valid}, 32'd0);
        chk("rst_pc",    idx, if_pc, 32'h0);
        chk("rst_inst",  idx, if_inst, NOP);
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("rst_perf_fetch", idx, perf_fetch_cnt, 32'd0);
        chk("rst_perf_flush", idx, perf_flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        id_ready       = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        //            rv ra            idr gnt rvl rd              req addr          val pc            inst
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          0, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h0,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hA000_0000,  0, 32'h4,        0, 32'h0,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h4,        1, 32'h0,        32'hA000_0000));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hA000_0001,  0, 32'h8,        0, 32'h0,        NOP));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 32'h0,    0, 1, 0, 32'h0,          0, 32'h8,        1, 32'h4,        32'hA000_0001));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h8,        1, 32'h4,        32'hA000_0001));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hA000_0002,  0, 32'hC,        0, 32'h4,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'hC,        1, 32'h8,        32'hA000_0002));
        tbl.push_back(mk(1, 32'h100,      1, 0, 0, 32'h0,          0, 32'h10,       0, 32'h8,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          0, 32'h100,      0, 32'h8,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hDEAD_DEAD,  0, 32'h100,      0, 32'h8,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h100,      0, 32'h8,        NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hB000_0000,  0, 32'h104,      0, 32'h8,        NOP));
        tbl.push_back(mk(1, 32'h203,      1, 1, 0, 32'h0,          1, 32'h104,      1, 32'h100,      32'hB000_0000));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hDEAD_BEEF,  0, 32'h200,      0, 32'h100,      NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          1, 32'h200,      0, 32'h100,      NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h200,      0, 32'h100,      NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hC000_0000,  0, 32'h204,      0, 32'h100,      NOP));
        tbl.push_back(mk(1, 32'hFFFF_FFFC,1, 0, 0, 32'h0,          1, 32'h204,      1, 32'h200,      32'hC000_0000));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,0, 32'h200,      NOP));
        tbl.push_back(mk(0, 32'h0,        1, 0, 1, 32'hD000_0000,  0, 32'h0,        0, 32'h200,      NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h0,        1, 32'hFFFF_FFFC,32'hD000_0000));
        tbl.push_back(mk(1, 32'h40,       1, 0, 1, 32'hD000_0001,  0, 32'h4,        0, 32'hFFFF_FFFC,NOP));
        tbl.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h40,       0, 32'hFFFF_FFFC,NOP));

        // Reset pulse mid-WAIT: stale response lands in IDLE and REQ and must be ignored.
        seq.push_back(mk(0, 32'h0,        1, 1, 1, 32'hBADB_AD00,  0, 32'h0,        0, 32'h0,        NOP));
        seq.push_back(mk(0, 32'h0,        1, 1, 1, 32'hBADB_AD01,  1, 32'h0,        0, 32'h0,        NOP));
        seq.push_back(mk(0, 32'h0,        1, 0, 1, 32'hE000_0000,  0, 32'h4,        0, 32'h0,        NOP));
        seq.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h4,        1, 32'h0,        32'hE000_0000));
        seq.push_back(mk(0, 32'h0,        1, 0, 1, 32'hE000_0001,  0, 32'h8,        0, 32'h0,        NOP));
        seq.push_back(mk(0, 32'h0,        1, 1, 0, 32'h0,          1, 32'h8,        1, 32'h4,        32'hE000_0001));
        seq.push_back(mk(0, 32'h0,        1, 0, 1, 32'hE000_0002,  0, 32'hC,        0, 32'h4,        NOP));
        seq.push_back(mk(1, 32'h80,       1, 0, 0, 32'h0,          1, 32'hC,        1, 32'h8,        32'hE000_0002));
        seq.push_back(mk(0, 32'h0,        1, 0, 0, 32'h0,          1, 32'h80,       0, 32'h8,        NOP));

        repeat (2) @(negedge clk);
        #1;
        chk_reset(-1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], i);

`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_fetch_cnt", 100, perf_fetch_cnt, 32'd6);
        chk("perf_flush_cnt", 100, perf_flush_cnt, 32'd4);
`endif

        // Asynchronous reset while a request is outstanding.
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset(200);
        @(negedge clk);
        rst = 1'b0;

        foreach (seq[i]) apply(seq[i], 300 + i);

`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_fetch_cnt", 400, perf_fetch_cnt, 32'd3);
        chk("perf_flush_cnt", 400, perf_flush_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the IF stage. It owns the fetch PC and drives the instruction-memory request/grant/response handshake with at most one request in flight. It delivers fetched instructions to ID through a single registered valid/ready slot, and applies branch redirects by flushing the slot and dropping stale responses.

## Interface
- `ADDR_W`, 32: fetch address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, 32'h0000_0013: value held on `if_inst` when no instruction is valid.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_addr` in ADDR_W: redirect target.
- `id_ready` in 1: ID accepts the slot this cycle; low means stall.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address, equal to `fetch_pc`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: response instruction.
- `if_valid` out 1: slot holds a valid instruction.
- `if_pc` out ADDR_W: PC of the slot instruction.
- `if_inst` out 32: slot instruction.

## Operation
- States:
  - IDLE: only after reset.
  - REQ: issuing.
  - WAIT: one request outstanding.
  - DROP: outstanding response must be discarded.
- Registers:
  - `fetch_pc`: next address to request.
  - `inflight_pc`: address of the outstanding request.
  - Output slot: `if_valid`, `if_pc`, `if_inst`.
- IDLE goes to REQ unconditionally on the first clock after `rst` deasserts.
- REQ:
  - `imem_req` = (state==REQ) && (!if_valid || id_ready). The slot is therefore always free when the response arrives.
  - Handshake completes on `imem_req && imem_gnt`.
  - On handshake: `inflight_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4`, go to WAIT.
- WAIT: on `imem_rvalid`, load the slot (`if_valid<=1`, `if_pc<=inflight_pc`, `if_inst<=imem_rdata`) and go to REQ.
- DROP: on `imem_rvalid`, discard the data and go to REQ.
- Slot consumed on `if_valid && id_ready`:
  - `if_valid<=0` and `if_inst<=NOP_INST`, unless refilled in the same cycle.
  - While `if_valid && !id_ready`, `if_pc` and `if_inst` hold.
- Redirect has highest priority:
  - `if_valid<=0` (flush) and `fetch_pc<={redirect_addr[ADDR_W-1:2],2'b00}`.
  - From WAIT without `rvalid`: go to DROP.
  - From REQ with gnt in the same cycle: go to DROP; no `fetch_pc+4` update.
  - From WAIT with `rvalid` in the same cycle: data discarded, go to REQ.
  - From REQ without gnt, or from DROP: state unchanged.
- `imem_gnt` is ignored when `imem_req`=0. `imem_rvalid` is ignored in IDLE and REQ.
- Arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFC+4 = 0x0000_0000.

## Timing
- Reset values:
  - state IDLE
  - `imem_req`=0
  - `imem_addr`=`fetch_pc`=`inflight_pc`=RESET_PC
  - `if_valid`=0, `if_pc`=RESET_PC, `if_inst`=NOP_INST
- Reset asserted mid-request abandons the transaction; any later `rvalid` arrives in IDLE or REQ and is ignored.
- `imem_req` and `imem_addr` are combinational from registered state and `id_ready`.
- Minimum latency is 2 cycles from first `imem_req` to `if_valid` (gnt in cycle 0, `rvalid` in cycle 1, slot valid in cycle 2).
- Peak throughput is one instruction per 2 cycles.
- First `imem_req` occurs 1 cycle after reset release.
- After a redirect, `imem_addr` shows the target no earlier than the next cycle. If the redirect caused DROP, the target appears the cycle after the stale `rvalid`.

## Configuration
- `FETCH_CTRL_PERF_CNT_EN` defined adds two outputs:
  - `perf_fetch_cnt` out 32: counts `if_valid && id_ready` handshakes.
  - `perf_flush_cnt` out 32: counts `redirect_valid` cycles.
  - Both reset to 0, wrap at 2^32, and are unaffected by stall.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release, gnt=1, `rvalid` one cycle after each gnt, `id_ready`=1 -> `imem_addr` 0x0,0x4,0x8; `if_pc` 0x0,0x4,0x8 with matching `rdata`, each valid one cycle after its `rvalid`.
- Slot valid at PC 0x4 with `id_ready`=0 for 5 cycles -> `if_pc`/`if_inst` stable, `imem_req`=0 throughout; resumes requesting 0x8 the cycle `id_ready`=1.
- Redirect to 0x100 in WAIT, `rvalid` 2 cycles later -> `if_valid` drops next cycle, stale data never appears, next `imem_addr`=0x100 and next delivered `if_pc`=0x100.
- Redirect 0x203 with gnt in the same REQ cycle -> DROP; after stale `rvalid`, `imem_addr`=0x200.
- Redirect 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
- `rst` pulsed during WAIT, `rvalid` the cycle after release -> all outputs at reset values, response ignored, first request to RESET_PC.
- With `FETCH_CTRL_PERF_CNT_EN`, 3 deliveries + 1 redirect -> `perf_fetch_cnt`=3, `perf_flush_cnt`=1.
